// File: rtl/usb_pkg.sv
// usb_pkg
// Shared PID encodings for the full-speed OUT endpoint slice.
// Contents: token/data PIDs, handshake PIDs, and a data-PID classifier.
package usb_pkg;

  typedef logic [3:0] pid_t;

  localparam pid_t PID_OUT   = 4'b0001;
  localparam pid_t PID_SETUP = 4'b1101;
  localparam pid_t PID_DATA0 = 4'b0011;
  localparam pid_t PID_DATA1 = 4'b1011;

  localparam pid_t PID_ACK   = 4'b0010;
  localparam pid_t PID_NAK   = 4'b1010;
  localparam pid_t PID_STALL = 4'b1110;

  // True for DATA0/DATA1; bit 3 of these two PIDs is the data toggle.
  function automatic logic is_data_pid(input pid_t p);
    return (p == PID_DATA0) || (p == PID_DATA1);
  endfunction

endpackage

// File: rtl/usb_fs_out_ep_if.sv
// usb_fs_out_ep_if
// Bundles the decoder-side inputs, the payload read port and the handshake
// request of the OUT endpoint.
//   slave  : endpoint view (decoder strobes in, read port / handshake out)
//   master : driver view (decoder model and payload consumer)
interface usb_fs_out_ep_if;
  logic [6:0] dev_addr;
  logic       stall;
  logic       pkt_start;
  logic       pkt_end;
  logic [3:0] pid;
  logic [6:0] addr;
  logic [3:0] endp;
  logic       valid_packet;
  logic       rx_data_put;
  logic [7:0] rx_data;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic       pkt_done;
  logic [6:0] pkt_len;
  logic       hs_req;
  logic [3:0] hs_pid;

  modport slave (
    input  dev_addr, stall, pkt_start, pkt_end, pid, addr, endp,
           valid_packet, rx_data_put, rx_data, rd_ready,
    output rd_data, rd_valid, pkt_done, pkt_len, hs_req, hs_pid
  );

  modport master (
    output dev_addr, stall, pkt_start, pkt_end, pid, addr, endp,
           valid_packet, rx_data_put, rx_data, rd_ready,
    input  rd_data, rd_valid, pkt_done, pkt_len, hs_req, hs_pid
  );
endinterface

// File: rtl/usb_out_fifo.sv
// usb_out_fifo
// Payload buffer with a speculative write pointer: bytes of the packet in
// flight are written at wr_spec and only become readable once committed
// (wr_cmt <= wr_spec). A rollback discards them (wr_spec <= wr_cmt).
// Ports:
//   clk, reset_n           clock, async active-low reset
//   wr_en, wr_data         speculative byte write
//   commit, rollback       end-of-packet decision (mutually exclusive)
//   ovf                    sticky: a write was attempted while full
//   rd_data, rd_valid      registered read port
//   rd_ready               consumer accepts when rd_valid && rd_ready
module usb_out_fifo #(
  parameter int DEPTH = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       commit,
  input  logic       rollback,
  output logic       ovf,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_cmt_q, wr_cmt_d;
  logic [PW-1:0] wr_spec_q, wr_spec_d;
  logic          ovf_q, ovf_d;
  logic          rd_valid_q, rd_valid_d;
  logic [7:0]    rd_data_q;
  logic          full_s, pop_s, wr_fire_s;

  // Pointer, overflow and read-port next-state logic.
  always_comb begin
    full_s    = (wr_spec_q - rd_ptr_q) == DEPTH_P;
    pop_s     = rd_valid_q && rd_ready;
    wr_fire_s = 1'b0;
    wr_cmt_d  = wr_cmt_q;
    wr_spec_d = wr_spec_q;
    ovf_d     = ovf_q;
    if (commit) begin
      wr_cmt_d = wr_spec_q;
      ovf_d    = 1'b0;
    end else if (rollback) begin
      wr_spec_d = wr_cmt_q;
      ovf_d     = 1'b0;
    end else if (wr_en) begin
      if (full_s) begin
        ovf_d = 1'b1;
      end else begin
        wr_fire_s = 1'b1;
        wr_spec_d = wr_spec_q + {{AW{1'b0}}, 1'b1};
      end
    end else begin
      wr_fire_s = 1'b0;
    end
    // rd_ptr addresses the byte currently presented; it advances on pop.
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop_s};
    // Uses the registered commit pointer, so a commit shows up a cycle later.
    rd_valid_d = (wr_cmt_q != rd_ptr_d);
  end

  // Storage array (no reset needed; validity comes from the pointers).
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_q[wr_spec_q[AW-1:0]] <= wr_data;
    end
  end

  // Pointer, flag and read-port registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q   <= '0;
      wr_cmt_q   <= '0;
      wr_spec_q  <= '0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_cmt_q   <= wr_cmt_d;
      wr_spec_q  <= wr_spec_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  assign ovf      = ovf_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
endmodule

// File: rtl/usb_fs_out_ep.sv
// usb_fs_out_ep
// Full-speed OUT/SETUP endpoint receive stage. Matches tokens against the
// device address and EP_NUM, buffers the following DATA0/DATA1 payload with
// the two CRC16 bytes stripped by a 2-byte delay line, then commits or rolls
// back the packet and requests ACK/NAK/STALL two cycles after pkt_end.
// Ports:
//   clk, reset_n   clock, async active-low reset
//   bus (slave)    decoder strobes/fields, payload read port, handshake request
// Build option: USB_OUT_TOGGLE_CHECK_EN enables the data-toggle check
// (duplicates are ACKed and discarded); without it every good packet commits.
module usb_fs_out_ep
  import usb_pkg::*;
#(
  parameter int EP_NUM        = 1,
  parameter int DEPTH         = 64,
  parameter int TOKEN_TIMEOUT = 255
) (
  input logic            clk,
  input logic            reset_n,
  usb_fs_out_ep_if.slave bus
);
  localparam int TW = $clog2(TOKEN_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_P = TW'(TOKEN_TIMEOUT);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_DATA = 2'd1;
  localparam logic [1:0] RX        = 2'd2;
  localparam logic [1:0] DECIDE    = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [3:0]    pid_q, pid_d;
  logic          vld_q, vld_d;
  logic [6:0]    cnt_q, cnt_d;
  logic [7:0]    dl0_q, dl0_d, dl1_q, dl1_d;
  logic          hs_req_q, hs_req_d;
  logic [3:0]    hs_pid_q, hs_pid_d;
  logic          pkt_done_q, pkt_done_d;
  logic [6:0]    pkt_len_q, pkt_len_d;
`ifdef USB_OUT_TOGGLE_CHECK_EN
  logic          toggle_q, toggle_d;
`endif
  logic          token_hit_s, data_ok_s;
  logic          fifo_wr_s, commit_s, rollback_s, ovf_s;

  assign token_hit_s = bus.pkt_end && bus.valid_packet &&
                       ((bus.pid == PID_OUT) || (bus.pid == PID_SETUP)) &&
                       (bus.addr == bus.dev_addr) && (bus.endp == 4'(EP_NUM));

  // A runt (fewer than the 2 CRC bytes) counts as a bad packet.
  assign data_ok_s = vld_q && is_data_pid(pid_q) && (cnt_q >= 7'd2);

  // FSM, delay line and decision logic.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    pid_d      = pid_q;
    vld_d      = vld_q;
    cnt_d      = cnt_q;
    dl0_d      = dl0_q;
    dl1_d      = dl1_q;
    hs_req_d   = 1'b0;
    hs_pid_d   = hs_pid_q;
    pkt_done_d = 1'b0;
    pkt_len_d  = pkt_len_q;
    fifo_wr_s  = 1'b0;
    commit_s   = 1'b0;
    rollback_s = 1'b0;
`ifdef USB_OUT_TOGGLE_CHECK_EN
    toggle_d   = toggle_q;
`endif
    case (state_q)
      IDLE: begin
        if (token_hit_s) begin
          state_d = WAIT_DATA;
          tmr_d   = TIMEOUT_P;
`ifdef USB_OUT_TOGGLE_CHECK_EN
          if (bus.pid == PID_SETUP) toggle_d = 1'b0;
          else                      toggle_d = toggle_q;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_DATA: begin
        if (bus.pkt_start) begin
          state_d = RX;
          cnt_d   = 7'd0;
        end else if (bus.pkt_end || (tmr_q == '0)) begin
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q - {{(TW-1){1'b0}}, 1'b1};
        end
      end
      RX: begin
        if (bus.rx_data_put) begin
          dl0_d = bus.rx_data;
          dl1_d = dl0_q;
          // Only a byte pushed out by two newer ones is payload.
          fifo_wr_s = (cnt_q >= 7'd2);
          if (cnt_q != 7'h7F) cnt_d = cnt_q + 7'd1;
          else                cnt_d = cnt_q;
        end else begin
          fifo_wr_s = 1'b0;
        end
        if (bus.pkt_end) begin
          state_d = DECIDE;
          pid_d   = bus.pid;
          vld_d   = bus.valid_packet;
        end else begin
          state_d = RX;
        end
      end
      DECIDE: begin
        state_d = IDLE;
        if (!data_ok_s) begin
          rollback_s = 1'b1;
        end else if (bus.stall) begin
          rollback_s = 1'b1;
          hs_req_d   = 1'b1;
          hs_pid_d   = PID_STALL;
        end else if (ovf_s) begin
          rollback_s = 1'b1;
          hs_req_d   = 1'b1;
          hs_pid_d   = PID_NAK;
        end
`ifdef USB_OUT_TOGGLE_CHECK_EN
        else if (pid_q[3] != toggle_q) begin
          // Retransmission of a packet already accepted: ACK, drop.
          rollback_s = 1'b1;
          hs_req_d   = 1'b1;
          hs_pid_d   = PID_ACK;
        end
`endif
        else begin
          commit_s   = 1'b1;
          hs_req_d   = 1'b1;
          hs_pid_d   = PID_ACK;
          pkt_done_d = 1'b1;
          pkt_len_d  = cnt_q - 7'd2;
`ifdef USB_OUT_TOGGLE_CHECK_EN
          toggle_d   = ~toggle_q;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      pid_q      <= 4'h0;
      vld_q      <= 1'b0;
      cnt_q      <= 7'd0;
      dl0_q      <= 8'h00;
      dl1_q      <= 8'h00;
      hs_req_q   <= 1'b0;
      hs_pid_q   <= 4'h0;
      pkt_done_q <= 1'b0;
      pkt_len_q  <= 7'd0;
`ifdef USB_OUT_TOGGLE_CHECK_EN
      toggle_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      pid_q      <= pid_d;
      vld_q      <= vld_d;
      cnt_q      <= cnt_d;
      dl0_q      <= dl0_d;
      dl1_q      <= dl1_d;
      hs_req_q   <= hs_req_d;
      hs_pid_q   <= hs_pid_d;
      pkt_done_q <= pkt_done_d;
      pkt_len_q  <= pkt_len_d;
`ifdef USB_OUT_TOGGLE_CHECK_EN
      toggle_q   <= toggle_d;
`endif
    end
  end

  usb_out_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (fifo_wr_s),
    .wr_data  (dl1_q),
    .commit   (commit_s),
    .rollback (rollback_s),
    .ovf      (ovf_s),
    .rd_data  (bus.rd_data),
    .rd_valid (bus.rd_valid),
    .rd_ready (bus.rd_ready)
  );

  assign bus.hs_req   = hs_req_q;
  assign bus.hs_pid   = hs_pid_q;
  assign bus.pkt_done = pkt_done_q;
  assign bus.pkt_len  = pkt_len_q;
endmodule
